// File: rtl/debounce_fsm.sv
// debounce_fsm: switch debouncer driven by an external periodic sample tick.
// The raw switch is passed through a two-flop synchronizer. A four-state FSM
// (ZERO, WAIT1, ONE, WAIT0) then changes the filtered level only after the
// synchronized input has held its new value for N_TICKS sample ticks.
// Outputs are a clean registered level and a one-cycle rising-edge pulse.
// Optional build macro DEBOUNCE_FALL_TICK_EN adds db_fall_tick, a one-cycle
// pulse on each completed 1->0 debounce.
module debounce_fsm #(
  parameter int N_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  input  logic tick,
`ifdef DEBOUNCE_FALL_TICK_EN
  output logic db_fall_tick,
`endif
  output logic db_level,
  output logic db_tick
);

  localparam int CNT_W = $clog2(N_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TICKS - 1);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sync_q;
  logic             sw_sync;

  assign sw_sync = sync_q[1];

  // Two-flop synchronizer: sync_q[1] is the metastability-safe copy of sw,
  // lagging the raw input by two clock cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], sw};
    end
  end

  // Debounce FSM. The outputs are assigned together with the next state, so
  // db_level mirrors the state being entered and the pulses appear on the
  // first cycle of the new stable state. A change of sw_sync while waiting
  // aborts the wait before any tick in the same cycle is considered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ZERO;
      cnt      <= '0;
      db_level <= 1'b0;
      db_tick  <= 1'b0;
`ifdef DEBOUNCE_FALL_TICK_EN
      db_fall_tick <= 1'b0;
`endif
    end else begin
      db_tick <= 1'b0;
`ifdef DEBOUNCE_FALL_TICK_EN
      db_fall_tick <= 1'b0;
`endif
      case (state)
        ZERO: begin
          if (sw_sync) begin
            state <= WAIT1;
            cnt   <= '0;
          end
        end
        WAIT1: begin
          if (!sw_sync) begin
            state <= ZERO;
            cnt   <= '0;
          end else if (tick && (cnt == CNT_LAST)) begin
            state    <= ONE;
            cnt      <= '0;
            db_level <= 1'b1;
            db_tick  <= 1'b1;
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        ONE: begin
          if (!sw_sync) begin
            state <= WAIT0;
            cnt   <= '0;
          end
        end
        WAIT0: begin
          if (sw_sync) begin
            state <= ONE;
            cnt   <= '0;
          end else if (tick && (cnt == CNT_LAST)) begin
            state    <= ZERO;
            cnt      <= '0;
            db_level <= 1'b0;
`ifdef DEBOUNCE_FALL_TICK_EN
            db_fall_tick <= 1'b1;
`endif
          end else if (tick) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state    <= ZERO;
          cnt      <= '0;
          db_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: scoreboard bench for debounce_fsm (N_TICKS = 4).
// A driver applies one input vector per clock, steps a behavioural model and
// queues the expected outputs; an independent monitor pops one entry after
// every rising edge and compares it with the DUT.
module tb_debounce_fsm;

  localparam int N = 4;

  typedef struct {
    logic level;
    logic rise;
    logic fall;
    int   cyc;
  } expT;

  logic clk;
  logic reset;
  logic sw;
  logic tick;
  logic dbLevel;
  logic dbTick;
`ifdef DEBOUNCE_FALL_TICK_EN
  logic dbFallTick;
`endif

  expT expQ[$];
  int  checks;
  int  errors;
  int  cycle;
  int  phase;
  bit  driverDone;

  // Behavioural model: raw sw samples from the last two edges, the filtered
  // level, whether a difference has already been noticed, and how many ticks
  // have arrived while the input kept differing from the level.
  logic swHist0;
  logic swHist1;
  logic mLevel;
  bit   mDiffSeen;
  int   mTicks;

  debounce_fsm #(.N_TICKS(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .sw      (sw),
    .tick    (tick),
`ifdef DEBOUNCE_FALL_TICK_EN
    .db_fall_tick(dbFallTick),
`endif
    .db_level(dbLevel),
    .db_tick (dbTick)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs at the falling edge and queue what the next
  // rising edge should produce according to the model.
  task automatic applyStimulus(input logic r, input logic s, input logic t);
    expT  e;
    logic swSync;
    @(negedge clk);
    reset = r;
    sw    = s;
    tick  = t;
    e.rise = 1'b0;
    e.fall = 1'b0;
    if (r) begin
      swHist0   = 1'b0;
      swHist1   = 1'b0;
      mLevel    = 1'b0;
      mDiffSeen = 1'b0;
      mTicks    = 0;
    end else begin
      swSync = swHist1;
      if (swSync == mLevel) begin
        mDiffSeen = 1'b0;
        mTicks    = 0;
      end else if (!mDiffSeen) begin
        mDiffSeen = 1'b1;
        mTicks    = 0;
      end else if (t) begin
        mTicks = mTicks + 1;
        if (mTicks == N) begin
          mLevel    = swSync;
          e.rise    = swSync;
          e.fall    = ~swSync;
          mDiffSeen = 1'b0;
          mTicks    = 0;
        end
      end
      swHist1 = swHist0;
      swHist0 = s;
    end
    e.level = mLevel;
    e.cyc   = cycle;
    cycle++;
    expQ.push_back(e);
  endtask

  // Hold sw constant for n cycles with a tick every 'period' cycles.
  task automatic runSeg(input int n, input logic s, input int period);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, s, (phase % period) == (period - 1));
      phase++;
    end
  endtask

  task automatic checkOutput(input expT e);
    checks++;
    if (dbLevel !== e.level) begin
      errors++;
      $display("[TB] FAIL db_level cycle %0d: got %b expected %b", e.cyc, dbLevel, e.level);
    end
    checks++;
    if (dbTick !== e.rise) begin
      errors++;
      $display("[TB] FAIL db_tick cycle %0d: got %b expected %b", e.cyc, dbTick, e.rise);
    end
`ifdef DEBOUNCE_FALL_TICK_EN
    checks++;
    if (dbFallTick !== e.fall) begin
      errors++;
      $display("[TB] FAIL db_fall_tick cycle %0d: got %b expected %b", e.cyc, dbFallTick, e.fall);
    end
`endif
  endtask

  // Monitor: after each rising edge, compare the DUT against the oldest
  // queued expectation.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Directed scenarios followed by randomized bouncing.
  initial begin
    checks = 0;
    errors = 0;
    cycle  = 0;
    phase  = 0;
    driverDone = 1'b0;
    reset = 1'b0;
    sw    = 1'b0;
    tick  = 1'b0;
    swHist0 = 1'b0;
    swHist1 = 1'b0;
    mLevel  = 1'b0;
    mDiffSeen = 1'b0;
    mTicks  = 0;

    $display("[TB] reset held with sw=1 tick=1");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1);
    runSeg(60, 1'b1, 10);

    $display("[TB] clean release and clean press");
    runSeg(60, 1'b0, 10);
    runSeg(60, 1'b1, 10);

    $display("[TB] bouncing press");
    runSeg(60, 1'b0, 10);
    runSeg(25, 1'b1, 10);
    runSeg(5, 1'b0, 10);
    runSeg(60, 1'b1, 10);

    $display("[TB] bouncing release");
    runSeg(15, 1'b0, 10);
    runSeg(3, 1'b1, 10);
    runSeg(60, 1'b0, 10);

    $display("[TB] abort coinciding with final tick");
    runSeg(10, 1'b0, 10);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    runSeg(10, 1'b0, 10);

    $display("[TB] reset during WAIT1");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    runSeg(30, 1'b1, 3);

    $display("[TB] randomized bouncing");
    for (int seg = 0; seg < 120; seg++) begin
      automatic logic s = 1'($urandom_range(0, 1));
      automatic int len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        applyStimulus(($urandom_range(0, 399) == 0), s, ($urandom_range(0, 3) == 0));
      end
    end
    runSeg(40, 1'b0, 2);
    driverDone = 1'b1;
  end

  // Finish once the scoreboard drains, with a bounded wait.
  initial begin
    wait (driverDone);
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_fsm.md
Name: debounce_fsm

Overview:
Switch debouncer that consumes the periodic sample tick from the upstream mod-M tick generator. It synchronizes a raw mechanical switch input and runs a four-state FSM. The filtered level changes only after the input has been stable for N_TICKS consecutive sample ticks. Outputs are a clean level and a one-cycle rising-edge pulse for downstream logic such as counters and LEDs.

Parameters:
N_TICKS, 4, number of sample ticks the synchronized input must stay stable before the output changes; legal range >= 1.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
sw  input  1  raw asynchronous switch input; may bounce.
tick  input  1  one-cycle sample strobe from the upstream tick generator; may be high on any cycle, including consecutive cycles.
db_level  output  1  debounced switch level; registered.
db_tick  output  1  one-cycle pulse on each debounced 0->1 transition; registered.

Behaviour:
- Synchronizer: 2-FF chain on sw gives sw_sync. The chain resets to 0. Input-to-sw_sync latency is 2 cycles.
- Counter cnt: width $clog2(N_TICKS+1), resets to 0.
- Reset (synchronous): state=ZERO, cnt=0, db_level=0, db_tick=0, sync FFs=0. Reset overrides every other event, including reset asserted mid-WAIT1 or mid-WAIT0.
- ZERO: db_level=0.
  - If sw_sync=1: go to WAIT1, cnt<=0.
- WAIT1: db_level=0.
  - If sw_sync=0: go to ZERO, cnt<=0. This abort has priority over a tick in the same cycle.
  - Else if tick and cnt==N_TICKS-1: go to ONE, cnt<=0, db_tick<=1.
  - Else if tick: cnt<=cnt+1.
  - Else: hold.
- ONE: db_level=1.
  - If sw_sync=0: go to WAIT0, cnt<=0.
- WAIT0: db_level=1.
  - If sw_sync=1: go to ONE, cnt<=0. Abort has priority, as in WAIT1.
  - Else if tick and cnt==N_TICKS-1: go to ZERO, cnt<=0.
  - Else if tick: cnt<=cnt+1.
- db_level and db_tick are registered from the next state.
  - db_tick is high for exactly one cycle: the first cycle the state is ONE.
  - db_level rises in that same cycle.
- Debounce window: between N_TICKS-1 and N_TICKS tick periods after sw_sync settles, depending on tick phase.
- Ticks arriving in ZERO or ONE are ignored.
- With N_TICKS=1: the first tick seen in WAIT1 or WAIT0 completes the transition.
- Glitch behaviour: any sw_sync glitch shorter than the window leaves db_level unchanged and produces no db_tick.
- The counter never exceeds N_TICKS-1; there is no wrap-around.

Optional Feature:
DEBOUNCE_FALL_TICK_EN
- Defined: adds output port db_fall_tick (1 bit, registered, reset 0). It pulses for exactly one cycle, the first cycle the state is ZERO after leaving WAIT0 on a completed count. It does not pulse after reset or after a WAIT1 abort.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold reset 3 cycles with sw=1 and tick=1 -> db_level=0, db_tick=0 throughout; after release, db_level is still 0 until the full window elapses.
2. Clean press: N_TICKS=4, tick every 10 cycles, sw 0->1 and held -> db_level rises on the cycle after the 4th tick in WAIT1; db_tick is high exactly 1 cycle; no further db_tick while held.
3. Bounce on press: sw=1 for 25 cycles (2 ticks), then 0 for 5, then held 1 -> no db_tick during the bounce; the count restarts and db_level rises only after 4 fresh ticks.
4. Release with bounce: from ONE, sw drops for 15 cycles, returns to 1 for 3, then drops and is held -> db_level stays 1 until 4 stable ticks; db_tick stays 0. With DEBOUNCE_FALL_TICK_EN defined, db_fall_tick pulses once, as db_level falls.
5. Simultaneous event: sw_sync falls in the same cycle as the 4th tick in WAIT1 -> state returns to ZERO, db_level=0, no db_tick.
6. Reset mid-operation: reset asserted in WAIT1 after 3 ticks -> next cycle state is ZERO with cnt=0; with sw held 1, the next rise needs a full 4 ticks plus 2 sync cycles.
